// File: rtl/video_sdram_arbiter.sv
// Arbitrates the rotation read port, the capture write port and a generic port onto
// one SDRAM command channel, with periodic refresh requests interleaved between commands.
//
//   state   | meaning
//   IDLE    | no backend operation outstanding; choose refresh or a client
//   ISSUE   | cmd_valid held with latched fields until cmd_ready
//   WAIT    | command accepted, waiting for cmd_done
//   REFRESH | ref_req held until ref_done
module video_sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 750,
  parameter int MAX_VID_RUN      = 8
) (
  input  logic        clk_96,
  input  logic        reset_n,

  input  logic        vidout_req,
  input  logic [9:0]  vidout_row,
  input  logic [9:0]  vidout_col,
  input  logic        vidout_frame,
  output logic [15:0] vidout_q,
  output logic        vidout_ack,

  input  logic        vidin_req,
  input  logic [9:0]  vidin_row,
  input  logic [9:0]  vidin_col,
  input  logic        vidin_frame,
  input  logic [15:0] vidin_d,
  output logic        vidin_ack,

  input  logic        port1_req,
  input  logic        port1_we,
  input  logic [23:0] port1_addr,
  input  logic [15:0] port1_d,
  output logic [15:0] port1_q,
  output logic        port1_ack,

  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_we,
  output logic [23:0] cmd_addr,
  output logic [15:0] cmd_d,
  input  logic        cmd_done,
  input  logic [15:0] cmd_q,

  output logic        ref_req,
  input  logic        ref_done
);

  localparam int TW = $clog2(REFRESH_INTERVAL + 1);
  localparam int VW = $clog2(MAX_VID_RUN + 1);
  localparam logic [TW-1:0] REF_RELOAD = TW'(REFRESH_INTERVAL - 1);
  localparam logic [VW-1:0] RUN_MAX    = VW'(MAX_VID_RUN);

  localparam logic [1:0] CL_VO = 2'd0;
  localparam logic [1:0] CL_VI = 2'd1;
  localparam logic [1:0] CL_P1 = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REFRESH} state_t;

  state_t          state;
  logic [1:0]      client;
  logic [TW-1:0]   ref_cnt;
  logic            refresh_pending;
  logic [VW-1:0]   vid_run;
  logic            rst_settled;

  logic            vo_eff, vi_eff, p1_eff;
  logic            grant_vld;
  logic [1:0]      grant_id;

  function automatic logic [23:0] vid_addr(input logic frame, input logic [9:0] row,
                                           input logic [9:0] col);
    return {2'b01, 1'b0, frame, row, col};
  endfunction

  // A req still high during its own ack cycle is the old request, not a new one.
  assign vo_eff = vidout_req & ~vidout_ack;
  assign vi_eff = vidin_req  & ~vidin_ack;
  assign p1_eff = port1_req  & ~port1_ack;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = CL_VO;
    if (p1_eff && (vid_run == RUN_MAX)) begin
      grant_vld = 1'b1;
      grant_id  = CL_P1;
    end else if (vo_eff) begin
      grant_vld = 1'b1;
      grant_id  = CL_VO;
    end else if (vi_eff) begin
      grant_vld = 1'b1;
      grant_id  = CL_VI;
    end else if (p1_eff) begin
      grant_vld = 1'b1;
      grant_id  = CL_P1;
    end
  end

  always_ff @(posedge clk_96 or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      client          <= CL_VO;
      ref_cnt         <= REF_RELOAD;
      refresh_pending <= 1'b0;
      vid_run         <= '0;
      rst_settled     <= 1'b0;
      vidout_q        <= '0;
      vidout_ack      <= 1'b0;
      vidin_ack       <= 1'b0;
      port1_q         <= '0;
      port1_ack       <= 1'b0;
      cmd_valid       <= 1'b0;
      cmd_we          <= 1'b0;
      cmd_addr        <= '0;
      cmd_d           <= '0;
      ref_req         <= 1'b0;
    end else begin
      rst_settled <= 1'b1;
      vidout_ack  <= 1'b0;
      vidin_ack   <= 1'b0;
      port1_ack   <= 1'b0;

      if (ref_cnt == '0) ref_cnt <= REF_RELOAD;
      else               ref_cnt <= ref_cnt - TW'(1);

      // Completion wins over a coincident expiry so only one refresh is ever queued.
      if ((state == REFRESH) && ref_done) refresh_pending <= 1'b0;
      else if (ref_cnt == '0)             refresh_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (rst_settled) begin
            if (!port1_req) vid_run <= '0;
            if (refresh_pending) begin
              ref_req <= 1'b1;
              state   <= REFRESH;
            end else if (grant_vld) begin
              client    <= grant_id;
              cmd_valid <= 1'b1;
              state     <= ISSUE;
              case (grant_id)
                CL_VO: begin
                  cmd_we   <= 1'b0;
                  cmd_addr <= vid_addr(vidout_frame, vidout_row, vidout_col);
                  cmd_d    <= '0;
                end
                CL_VI: begin
                  cmd_we   <= 1'b1;
                  cmd_addr <= vid_addr(vidin_frame, vidin_row, vidin_col);
                  cmd_d    <= vidin_d;
                end
                default: begin
                  cmd_we   <= port1_we;
                  cmd_addr <= port1_addr;
                  cmd_d    <= port1_d;
                end
              endcase
              if (grant_id == CL_P1)
                vid_run <= '0;
              else if (port1_req && (vid_run != RUN_MAX))
                vid_run <= vid_run + VW'(1);
            end
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cmd_done) begin
            case (client)
              CL_VO: begin
                vidout_ack <= 1'b1;
                vidout_q   <= cmd_q;
              end
              CL_VI: vidin_ack <= 1'b1;
              default: begin
                port1_ack <= 1'b1;
                if (!cmd_we) port1_q <= cmd_q;
              end
            endcase
            state <= IDLE;
          end
        end
        REFRESH: begin
          if (ref_done) begin
            ref_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_sdram_arbiter.sv
// Directed bench for video_sdram_arbiter: a vector table of single transactions plus
// hand-written sequences for fairness, refresh deferral, reset and spurious completions.
module tb_video_sdram_arbiter;

  logic        clk_96 = 1'b0;
  logic        reset_n;
  logic        vidout_req, vidout_frame, vidout_ack;
  logic [9:0]  vidout_row, vidout_col;
  logic [15:0] vidout_q;
  logic        vidin_req, vidin_frame, vidin_ack;
  logic [9:0]  vidin_row, vidin_col;
  logic [15:0] vidin_d;
  logic        port1_req, port1_we, port1_ack;
  logic [23:0] port1_addr;
  logic [15:0] port1_d, port1_q;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_done;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_d, cmd_q;
  logic        ref_req, ref_done;

  int n_pass  = 0;
  int n_total = 0;

  video_sdram_arbiter #(.REFRESH_INTERVAL(750), .MAX_VID_RUN(8)) dut (
    .clk_96(clk_96), .reset_n(reset_n),
    .vidout_req(vidout_req), .vidout_row(vidout_row), .vidout_col(vidout_col),
    .vidout_frame(vidout_frame), .vidout_q(vidout_q), .vidout_ack(vidout_ack),
    .vidin_req(vidin_req), .vidin_row(vidin_row), .vidin_col(vidin_col),
    .vidin_frame(vidin_frame), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
    .port1_req(port1_req), .port1_we(port1_we), .port1_addr(port1_addr),
    .port1_d(port1_d), .port1_q(port1_q), .port1_ack(port1_ack),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_d(cmd_d), .cmd_done(cmd_done), .cmd_q(cmd_q),
    .ref_req(ref_req), .ref_done(ref_done)
  );

  always #5 clk_96 = ~clk_96;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  client;
    logic [9:0]  row;
    logic [9:0]  col;
    logic        frame;
    logic        we;
    logic [23:0] addr;
    logic [15:0] d;
    int          ready_wait;
    int          done_wait;
    logic [15:0] q;
    logic        drop_req;
    logic [23:0] exp_addr;
    logic        exp_we;
    logic [15:0] exp_d;
    logic [15:0] exp_q;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(negedge clk_96);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [2:0] acks();
    return {port1_ack, vidin_ack, vidout_ack};
  endfunction

  task automatic clear_inputs();
    vidout_req = 0; vidout_row = 0; vidout_col = 0; vidout_frame = 0;
    vidin_req = 0; vidin_row = 0; vidin_col = 0; vidin_frame = 0; vidin_d = 0;
    port1_req = 0; port1_we = 0; port1_addr = 0; port1_d = 0;
    cmd_ready = 0; cmd_done = 0; cmd_q = 0; ref_done = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    chk("rst_ctl", {acks(), cmd_valid, cmd_we, ref_req}, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_data", {vidout_q, port1_q, cmd_d}, 0);
    reset_n = 1'b1;
  endtask

  // Waits for cmd_valid, servicing any refresh that gets in the way.
  task automatic wait_cmd(output int lat);
    lat = 0;
    while (!cmd_valid && lat < 40) begin
      ref_done = ref_req;
      tick();
      lat++;
    end
    ref_done = 0;
    if (!cmd_valid) chk("cmd_valid_timeout", 0, 1);
  endtask

  task automatic finish_txn(input logic [1:0] client, input int done_wait,
                            input logic [15:0] q);
    cmd_ready = 1; tick(); cmd_ready = 0;
    chk("valid_drop", cmd_valid, 0);
    repeat (done_wait) tick();
    chk("no_early_ack", acks(), 0);
    cmd_done = 1; cmd_q = q; tick();
    cmd_done = 0; cmd_q = 16'h0;
    chk("ack", acks(), 3'b001 << client);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    case (v.client)
      2'd0: begin vidout_req = 1; vidout_row = v.row; vidout_col = v.col; vidout_frame = v.frame; end
      2'd1: begin vidin_req = 1; vidin_row = v.row; vidin_col = v.col; vidin_frame = v.frame; vidin_d = v.d; end
      default: begin port1_req = 1; port1_we = v.we; port1_addr = v.addr; port1_d = v.d; end
    endcase
    wait_cmd(lat);
    chk("grant_lat", lat, 1);
    if (v.drop_req) begin vidout_req = 0; vidin_req = 0; port1_req = 0; end
    chk("cmd_addr", cmd_addr, v.exp_addr);
    chk("cmd_we", cmd_we, v.exp_we);
    chk("cmd_d", cmd_d, v.exp_d);
    for (int i = 0; i < v.ready_wait; i++) begin
      tick();
      chk("cmd_hold", {cmd_valid, cmd_we, cmd_addr, cmd_d}, {1'b1, v.exp_we, v.exp_addr, v.exp_d});
    end
    finish_txn(v.client, v.done_wait, v.q);
    if (v.client == 2'd0) chk("vidout_q", vidout_q, v.exp_q);
    if (v.client == 2'd2) chk("port1_q", port1_q, v.exp_q);
    vidout_req = 0; vidin_req = 0; port1_req = 0;
    tick();
    chk("ack_once", acks(), 0);
  endtask

  initial begin
    int lat;
    int saw;
    logic [1:0] id;
    logic [1:0] exp_order [10];

    vecs[0] = '{2'd0, 10'd5,   10'd3,   1'b1, 1'b0, 24'h0,      16'h0,    0, 4, 16'hBEEF, 1'b0, 24'h501403, 1'b0, 16'h0,    16'hBEEF};
    vecs[1] = '{2'd0, 10'd5,   10'd3,   1'b0, 1'b0, 24'h0,      16'h0,    1, 2, 16'h1234, 1'b0, 24'h401403, 1'b0, 16'h0,    16'h1234};
    vecs[2] = '{2'd1, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 24'h0,      16'hCAFE, 0, 1, 16'hDEAD, 1'b0, 24'h5FFFFF, 1'b1, 16'hCAFE, 16'h0};
    vecs[3] = '{2'd2, 10'd0,   10'd0,   1'b0, 1'b1, 24'h001234, 16'h00A5, 3, 2, 16'hDEAD, 1'b0, 24'h001234, 1'b1, 16'h00A5, 16'h0000};
    vecs[4] = '{2'd2, 10'd0,   10'd0,   1'b0, 1'b0, 24'hFFFFFF, 16'h1111, 0, 3, 16'h5A5A, 1'b0, 24'hFFFFFF, 1'b0, 16'h1111, 16'h5A5A};
    vecs[5] = '{2'd0, 10'd0,   10'd0,   1'b0, 1'b0, 24'h0,      16'h0,    2, 1, 16'h0001, 1'b1, 24'h400000, 1'b0, 16'h0,    16'h0001};
    vecs[6] = '{2'd1, 10'd2,   10'd1,   1'b0, 1'b0, 24'h0,      16'hFFFF, 1, 0, 16'h0,    1'b0, 24'h400801, 1'b1, 16'hFFFF, 16'h0};
    vecs[7] = '{2'd2, 10'd0,   10'd0,   1'b0, 1'b1, 24'h800000, 16'h0F0F, 0, 0, 16'hAAAA, 1'b0, 24'h800000, 1'b1, 16'h0F0F, 16'h5A5A};

    exp_order = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};

    do_reset();
    tick();
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // All three clients requesting continuously.
    do_reset();
    tick();
    vidout_req = 1; vidin_req = 1; port1_req = 1;
    port1_we = 0; port1_addr = 24'h000100;
    for (int i = 0; i < 10; i++) begin
      wait_cmd(lat);
      if (cmd_addr[23:22] == 2'b01) id = cmd_we ? 2'd1 : 2'd0;
      else id = 2'd2;
      chk("fair_order", id, exp_order[i]);
      finish_txn(id, 1, 16'(i));
    end
    vidout_req = 0; vidin_req = 0; port1_req = 0;
    repeat (2) tick();

    // Refresh expiry lands while a read is in WAIT.
    do_reset();
    repeat (740) tick();
    vidout_req = 1; vidin_req = 1; vidin_d = 16'h0001;
    wait_cmd(lat);
    cmd_ready = 1; tick(); cmd_ready = 0;
    saw = 0;
    repeat (13) begin tick(); saw |= int'(ref_req); end
    chk("ref_deferred", saw, 0);
    cmd_done = 1; cmd_q = 16'h3C3C; tick(); cmd_done = 0;
    chk("ref_ack_cycle", {vidout_ack, ref_req, cmd_valid}, 3'b100);
    vidout_req = 0;
    tick();
    chk("ref_rise", {ref_req, cmd_valid}, 2'b10);
    repeat (2) begin tick(); chk("ref_hold", {ref_req, cmd_valid}, 2'b10); end
    ref_done = 1; tick(); ref_done = 0;
    chk("ref_drop", ref_req, 0);
    wait_cmd(lat);
    chk("post_ref_lat", lat, 1);
    chk("post_ref_we", cmd_we, 1);
    finish_txn(2'd1, 1, 16'h0);
    vidin_req = 0;
    tick();

    // Asynchronous reset while a command is in ISSUE.
    do_reset();
    tick();
    vidout_req = 1; vidout_row = 10'd7; vidout_col = 10'd9; vidout_frame = 1;
    wait_cmd(lat);
    tick();
    #2 reset_n = 0;
    #1;
    chk("async_rst_ctl", {acks(), cmd_valid, cmd_we, ref_req}, 0);
    chk("async_rst_data", {cmd_addr, cmd_d, vidout_q}, 0);
    tick(); tick();
    chk("async_rst_noack", acks(), 0);
    reset_n = 1;
    lat = 0;
    while (!cmd_valid && lat < 10) begin tick(); lat++; end
    chk("rst_regrant_lat", lat, 2);
    chk("rst_regrant_addr", cmd_addr, 24'h501C09);
    finish_txn(2'd0, 1, 16'h4242);
    chk("rst_regrant_q", vidout_q, 16'h4242);
    vidout_req = 0;
    tick();

    // Completions arriving in the wrong state.
    do_reset();
    repeat (2) tick();
    cmd_done = 1; cmd_q = 16'hFFFF; tick(); cmd_done = 0;
    chk("spurious_done_ack", {acks(), cmd_valid, ref_req}, 0);
    chk("spurious_done_q", {vidout_q, port1_q}, 0);
    vidout_req = 1; vidout_row = 10'd1; vidout_col = 10'd1; vidout_frame = 0;
    wait_cmd(lat);
    cmd_ready = 1; tick(); cmd_ready = 0;
    ref_done = 1; tick(); ref_done = 0;
    chk("spurious_ref", {acks(), cmd_valid, ref_req}, 0);
    cmd_done = 1; cmd_q = 16'h7777; tick(); cmd_done = 0;
    chk("after_spurious_ack", acks(), 3'b001);
    chk("after_spurious_q", vidout_q, 16'h7777);
    vidout_req = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
